image_auto_saturation_ctrl: RTL
===============================

// Module: image_auto_saturation_ctrl
// PURPOSE
//  Closed-loop controller for the saturation-adjust stage. Taps that stage's output pixel
//  stream, measures the per-frame mean chroma spread (max(R,G,B)-min(R,G,B)), and at each
//  frame boundary steps the 9-bit signed adjust_val it feeds back to the stage. The step
//  moves the mean toward a target. Manual override is available.
// PARAMETERS
//  ACC_W     32   width of the spread-sum and pixel-count accumulators; also the divider iteration count
//  TARGET    64   desired mean spread, 0..255
//  DEADBAND  4    no adjustment while |mean-TARGET| <= DEADBAND
//  STEP      8    adjust_val change per frame, 1..255
//  ADJ_MAX   255  upper clamp of adjust_val (signed)
//  ADJ_MIN   -255 lower clamp of adjust_val (signed)
// PORTS
//  clk           in   1   pixel clock; single clock domain
//  reset         in   1   asynchronous, active-low reset
//  enable        in   1   1=auto control, 0=adjust_val follows manual_val
//  manual_val    in   9   signed manual adjust value, -255..255
//  vs_in         in   1   vertical sync, active high; rising edge = frame boundary
//  valid_i       in   1   pixel qualifier
//  img_data_i    in   24  {R[23:16],G[15:8],B[7:0]}
//  adjust_val    out  9   signed two's-complement adjust value to the saturation stage
//  adjust_update out  1   1-cycle pulse, one per completed UPDATE state
//  frame_mean    out  8   mean spread of the last measured frame
//  busy          out  1   high while the FSM is in DIVIDE or UPDATE
// BEHAVIOUR
//  Reset (reset=0):
//   - adjust_val=0, adjust_update=0, frame_mean=0, busy=0.
//   - Accumulators, flags and pipeline registers are cleared. FSM enters IDLE.
//   - Reset asserted mid-frame or mid-DIVIDE aborts all work.
//  Stage 1 (registered):
//   - spread = max-min, 8-bit unsigned; registered with spread_v=valid_i.
//   - vs_d1<=vs_in, so vs and pixels stay aligned.
//  Frame edge E: cycle where vs_d1=1 and vs_d2=0 (vs_d2 is a second register).
//   A spread_v pixel in cycle E belongs to the ending frame.
//  Accumulation (ACCUM, DIVIDE and UPDATE states):
//   - Each spread_v cycle: sum+=spread, cnt+=1.
//   - Either accumulator reaching all-ones saturates and sets ovf.
//  FSM:
//   - IDLE -> ACCUM at the first E. The partial frame after reset is discarded.
//   - ACCUM at E:
//     - If cnt!=0 and !ovf: latch sum/cnt (including the cycle-E pixel) into the divider
//       and go to DIVIDE.
//     - Otherwise: discard the frame and stay in ACCUM.
//     - In both cases sum/cnt/ovf restart at E+1 with the first pixel of the new frame.
//   - DIVIDE: restoring divider, ACC_W cycles (E+1..E+ACC_W), quotient=sum/cnt, truncated.
//     The quotient is <=255 by construction. Then go to UPDATE.
//   - E during DIVIDE/UPDATE: that frame is discarded and accumulators restart. The running
//     division completes unaffected.
//   - UPDATE (1 cycle, E+ACC_W+1):
//     - frame_mean<=quotient.
//     - If enable=1 and mean<TARGET-DEADBAND: adjust_val<=min(adjust_val+STEP, ADJ_MAX).
//     - If enable=1 and mean>TARGET+DEADBAND: adjust_val<=max(adjust_val-STEP, ADJ_MIN).
//     - Else adjust_val is unchanged.
//     - adjust_update=1 in the following cycle, E+ACC_W+2, even if the value did not change.
//     - Then go to ACCUM.
//   - Comparisons and clamping use 11-bit signed arithmetic, so nothing wraps.
//  enable=0:
//   - adjust_val<=manual_val every cycle (1-cycle latency), clamped to ADJ_MIN..ADJ_MAX.
//   - Measurement, frame_mean and adjust_update continue.
//   - When enable returns to 1, control resumes from the current adjust_val.
//  Outputs are registered; no combinational input->output paths.
// TESTING
//  1 Hold reset low, toggle inputs -> all outputs 0. Release, first vs edge -> no adjust_update.
//  2 R=G=B=100, 64 px/frame, enable=1 -> frame_mean=0; adjust_val climbs 8,16,...,248,
//    then stays at 255 from frame 32 onward.
//  3 All px (255,0,0) -> frame_mean=255; adjust_val 0,-8,... clamps at -255 (9'h101).
//  4 Half px spread 60, half spread 70 -> frame_mean=65, within the deadband -> adjust_val
//    unchanged; adjust_update still pulses at E+34.
//  5 enable=0, manual_val=-100 -> adjust_val=9'h19C next cycle; frame_mean still updated.
//    enable->1 -> steps start from -100.
//  6 10-px frames with blanking <34 cycles -> alternate frames discarded, no ovf.
//    Separately: reset asserted mid-DIVIDE -> all outputs 0, FSM back in IDLE.

Source files
------------

// File: rtl/image_auto_saturation_ctrl.sv
// ---------------------------------------------------------------------------
// image_auto_saturation_ctrl
//
// Closed-loop controller for the saturation-adjust stage. It measures the
// mean chroma spread (max(R,G,B)-min(R,G,B)) of each frame in the pixel
// stream it taps. At each frame boundary it moves the signed adjust value it
// feeds back to that stage by one step toward a target spread. When enable
// is low, adjust_val follows manual_val instead.
//
// Ports
//   clk           pixel clock (single domain)
//   reset         asynchronous, active-low reset
//   enable        1 = automatic control, 0 = adjust_val follows manual_val
//   manual_val    signed manual adjust value (clamped to ADJ_MIN..ADJ_MAX)
//   vs_in         vertical sync, rising edge marks a frame boundary
//   valid_i       pixel qualifier
//   img_data_i    {R,G,B} pixel, 8 bits per component
//   adjust_val    signed adjust value driven to the saturation stage
//   adjust_update one-cycle pulse after every completed update
//   frame_mean    mean spread of the last measured frame
//   busy          high while a division or update is in progress
// ---------------------------------------------------------------------------
module image_auto_saturation_ctrl #(
   parameter int ACC_W    = 32,
   parameter int TARGET   = 64,
   parameter int DEADBAND = 4,
   parameter int STEP     = 8,
   parameter int ADJ_MAX  = 255,
   parameter int ADJ_MIN  = -255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [8:0]  manual_val,
   input  logic        vs_in,
   input  logic        valid_i,
   input  logic [23:0] img_data_i,
   output logic [8:0]  adjust_val,
   output logic        adjust_update,
   output logic [7:0]  frame_mean,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_UPDATE} state_t;

   localparam int                CW       = $clog2(ACC_W) + 1;
   localparam logic [CW-1:0]     DIV_LAST = CW'(ACC_W - 1);
   localparam logic [ACC_W-1:0]  ACC_ONES = {ACC_W{1'b1}};
   localparam logic signed [10:0] LO_TH   = 11'(TARGET - DEADBAND);
   localparam logic signed [10:0] HI_TH   = 11'(TARGET + DEADBAND);
   localparam logic signed [10:0] STEP_S  = 11'(STEP);
   localparam logic signed [10:0] MAX_S   = 11'(ADJ_MAX);
   localparam logic signed [10:0] MIN_S   = 11'(ADJ_MIN);

   state_t            state_q, state_d;
   logic [7:0]        spread_q, spread_d;
   logic              spread_v_q;
   logic              vs_d1_q, vs_d2_q;
   logic [ACC_W-1:0]  sum_q, sum_d, cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [ACC_W-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
   logic [CW-1:0]     step_q, step_d;
   logic [8:0]        adj_q, adj_d;
   logic              upd_q, upd_d;
   logic [7:0]        mean_q, mean_d;
   logic              busy_q, busy_d;

   logic [7:0]        pix_r, pix_g, pix_b, pix_max, pix_min;
   logic              frame_edge, can_latch;
   logic [ACC_W:0]    sum_ext, cnt_ext, rem_shift;
   logic [ACC_W-1:0]  sum_inc, cnt_inc;
   logic              ovf_inc;
   logic signed [10:0] mean_s, adj_s, man_s, man_clamp, adj_up, adj_dn;

   // Stage 1: per-pixel spread.
   always_comb begin
      pix_r   = img_data_i[23:16];
      pix_g   = img_data_i[15:8];
      pix_b   = img_data_i[7:0];
      pix_max = pix_r;
      if (pix_g > pix_max) pix_max = pix_g;
      if (pix_b > pix_max) pix_max = pix_b;
      pix_min = pix_r;
      if (pix_g < pix_min) pix_min = pix_g;
      if (pix_b < pix_min) pix_min = pix_b;
      spread_d = pix_max - pix_min;
   end

   // vs is delayed twice so the edge lines up with the registered spread.
   assign frame_edge = vs_d1_q & ~vs_d2_q;

   // Accumulator values including this cycle's pixel; both saturate at
   // all-ones and flag the frame as unusable.
   always_comb begin
      sum_ext = {1'b0, sum_q} + {{(ACC_W - 7){1'b0}}, spread_q};
      cnt_ext = {1'b0, cnt_q} + {{ACC_W{1'b0}}, 1'b1};
      sum_inc = sum_q;
      cnt_inc = cnt_q;
      ovf_inc = ovf_q;
      if (spread_v_q) begin
         if (sum_ext >= {1'b0, ACC_ONES}) begin
            sum_inc = ACC_ONES;
            ovf_inc = 1'b1;
         end else begin
            sum_inc = sum_ext[ACC_W-1:0];
         end
         if (cnt_ext >= {1'b0, ACC_ONES}) begin
            cnt_inc = ACC_ONES;
            ovf_inc = 1'b1;
         end else begin
            cnt_inc = cnt_ext[ACC_W-1:0];
         end
      end
   end

   assign can_latch = frame_edge && (state_q == S_ACCUM) &&
                      (cnt_inc != '0) && !ovf_inc;

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (frame_edge) state_d = S_ACCUM;
         S_ACCUM:  if (can_latch) state_d = S_DIVIDE;
         S_DIVIDE: if (step_q == DIV_LAST) state_d = S_UPDATE;
         S_UPDATE: state_d = S_ACCUM;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and outputs.
   always_comb begin
      sum_d  = sum_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      rem_d  = rem_q;
      step_d = step_q;
      mean_d = mean_q;
      adj_d  = adj_q;
      upd_d  = 1'b0;

      // Every frame edge restarts measurement, whether or not the ending
      // frame is handed to the divider.
      if (state_q != S_IDLE) begin
         if (frame_edge) begin
            sum_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
         end else begin
            sum_d = sum_inc;
            cnt_d = cnt_inc;
            ovf_d = ovf_inc;
         end
      end

      // Restoring divider: the dividend register shifts out its MSB into
      // the partial remainder and shifts the quotient bit in at the bottom,
      // so after ACC_W steps it holds the quotient.
      rem_shift = {rem_q, dvd_q[ACC_W-1]};
      if (can_latch) begin
         dvd_d  = sum_inc;
         dvs_d  = cnt_inc;
         rem_d  = '0;
         step_d = '0;
      end else if (state_q == S_DIVIDE) begin
         step_d = step_q + CW'(1);
         if (rem_shift >= {1'b0, dvs_q}) begin
            rem_d = rem_shift[ACC_W-1:0] - dvs_q;
            dvd_d = {dvd_q[ACC_W-2:0], 1'b1};
         end else begin
            rem_d = rem_shift[ACC_W-1:0];
            dvd_d = {dvd_q[ACC_W-2:0], 1'b0};
         end
      end

      // 11-bit signed arithmetic keeps steps and clamps from wrapping.
      mean_s = {3'b000, dvd_q[7:0]};
      adj_s  = {{2{adj_q[8]}}, adj_q};
      man_s  = {{2{manual_val[8]}}, manual_val};
      adj_up = adj_s + STEP_S;
      adj_dn = adj_s - STEP_S;
      man_clamp = man_s;
      if (man_s > MAX_S) man_clamp = MAX_S;
      if (man_s < MIN_S) man_clamp = MIN_S;

      if (state_q == S_UPDATE) begin
         mean_d = dvd_q[7:0];
         upd_d  = 1'b1;
         if (enable) begin
            if (mean_s < LO_TH) begin
               adj_d = (adj_up > MAX_S) ? MAX_S[8:0] : adj_up[8:0];
            end else if (mean_s > HI_TH) begin
               adj_d = (adj_dn < MIN_S) ? MIN_S[8:0] : adj_dn[8:0];
            end
         end
      end
      if (!enable) adj_d = man_clamp[8:0];

      busy_d = (state_d == S_DIVIDE) || (state_d == S_UPDATE);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spread_q   <= '0;
         spread_v_q <= 1'b0;
         vs_d1_q    <= 1'b0;
         vs_d2_q    <= 1'b0;
         sum_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         rem_q      <= '0;
         step_q     <= '0;
         adj_q      <= '0;
         upd_q      <= 1'b0;
         mean_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         spread_q   <= spread_d;
         spread_v_q <= valid_i;
         vs_d1_q    <= vs_in;
         vs_d2_q    <= vs_d1_q;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         rem_q      <= rem_d;
         step_q     <= step_d;
         adj_q      <= adj_d;
         upd_q      <= upd_d;
         mean_q     <= mean_d;
         busy_q     <= busy_d;
      end
   end

   assign adjust_val    = adj_q;
   assign adjust_update = upd_q;
   assign frame_mean    = mean_q;
   assign busy          = busy_q;

endmodule
